// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The execute stage drives the master side; ex_muldiv sits on the slave side.
interface ex_muldiv_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [RD_W-1:0] rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [RD_W-1:0] rd_addr_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
    input  busy_o, done_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
    output busy_o, done_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32 M-extension unit: MSB-first shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up in a final cycle and a registered result.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_muldiv_if.slave bus,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned    LAST = XLEN - 1;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [XLEN-1:0]   cnt_q, a_q, b_q, rem_q, res_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2:0]        op_q;
  logic              sign_q, busy_q, done_q;
  logic [RD_W-1:0]   tag_q, rd_q;

  // Request decode: operand magnitudes, result sign and the special cases.
  logic            a_neg, b_neg, sign_d, special_d;
  logic [XLEN-1:0] a_mag_d, b_mag_d, special_res_d;

  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    sign_d = 1'b0;
    special_d = 1'b0;
    special_res_d = '0;
    unique case (bus.op_i)
      3'd1, 3'd4, 3'd6: begin
        a_neg = bus.rs1_i[XLEN-1];
        b_neg = bus.rs2_i[XLEN-1];
      end
      3'd2:    a_neg = bus.rs1_i[XLEN-1];
      default: ;
    endcase
    // DIV/MULH use the quotient sign rule; REM and MULHSU follow rs1 alone.
    unique case (bus.op_i)
      3'd1, 3'd4: sign_d = a_neg ^ b_neg;
      3'd2, 3'd6: sign_d = a_neg;
      default:    sign_d = 1'b0;
    endcase
    a_mag_d = a_neg ? -bus.rs1_i : bus.rs1_i;
    b_mag_d = b_neg ? -bus.rs2_i : bus.rs2_i;
    if (bus.op_i[2]) begin
      if (bus.rs2_i == '0) begin
        special_d = 1'b1;
        special_res_d = bus.op_i[1] ? bus.rs1_i : ONES;
      end else if (!bus.op_i[0] && bus.rs1_i == MINV && bus.rs2_i == ONES) begin
        special_d = 1'b1;
        special_res_d = bus.op_i[1] ? '0 : bus.rs1_i;
      end
    end
  end

  // One iteration of each datapath, plus the final sign/half selection.
  logic [2*XLEN-1:0] prod_d, prod_fix;
  logic [XLEN:0]     rem_shift, diff;
  logic [XLEN-1:0]   rem_d, div_val, fix_res;

  always_comb begin
    prod_d    = {prod_q[2*XLEN-2:0], 1'b0} + (b_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : '0);
    rem_shift = {rem_q, a_q[XLEN-1]};
    diff      = rem_shift - {1'b0, b_q};
    rem_d     = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    prod_fix  = sign_q ? -prod_q : prod_q;
    div_val   = op_q[1] ? rem_q : a_q;
    if (op_q[2])
      fix_res = sign_q ? -div_val : div_val;
    else if (op_q == 3'd0)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Handshake: start_i is accepted on any edge where busy_o is low (IDLE or DONE);
  // busy_o stays high until the result is loaded, done_o pulses for exactly one cycle
  // with result_o/rd_addr_o valid, and flush_i wins over everything except reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (bus.start_i) begin
            a_q    <= a_mag_d;
            b_q    <= b_mag_d;
            rem_q  <= '0;
            prod_q <= '0;
            sign_q <= sign_d;
            op_q   <= bus.op_i;
            tag_q  <= bus.rd_addr_i;
            cnt_q  <= '0;
            if (special_d) begin
              res_q   <= special_res_d;
              rd_q    <= bus.rd_addr_i;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            rem_q <= rem_d;
            a_q   <= {a_q[XLEN-2:0], ~diff[XLEN]};
          end else begin
            prod_q <= prod_d;
            b_q    <= {b_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST[XLEN-1:0]) state_q <= S_FIX;
        end
        S_FIX: begin
          res_q   <= fix_res;
          rd_q    <= tag_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.result_o  = res_q;
  assign bus.rd_addr_o = rd_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv at XLEN=32: op results, special cases, latency,
// flush, handshake corner cases and mid-operation reset.
module tb_ex_muldiv;
  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_o;
  int         n_checks = 0;
  int         n_fail = 0;

  ex_muldiv_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

  ex_muldiv #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // exp_lat counts edges from the sampling edge up to and including the done edge.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic saw_busy;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs1_i     = a;
    bus.rs2_i     = b;
    bus.rd_addr_i = tag;
    tick();
    bus.start_i   = 1'b0;
    bus.rs1_i     = $urandom;
    bus.rs2_i     = $urandom;
    bus.rd_addr_i = 5'($urandom_range(0, 31));
    bus.op_i      = 3'($urandom_range(0, 7));
    lat = 1;
    saw_busy = bus.busy_o;
    while (!bus.done_o && lat < 100) begin
      tick();
      lat++;
      saw_busy |= bus.busy_o;
    end
    chk({name, "_done"}, 32'(bus.done_o), 32'd1);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, bus.result_o, exp_res);
    chk({name, "_tag"}, 32'(bus.rd_addr_o), 32'(tag));
    chk({name, "_busyseen"}, 32'(saw_busy), 32'(exp_lat > 1));
    tick();
    chk({name, "_pulse"}, 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    int   cnt;
    int   ndone;
    logic [31:0] got_res;
    logic [4:0]  got_tag;

    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i = 3'd0;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    bus.rd_addr_i = '0;

    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_res", bus.result_o, 32'd0);
    chk("rst_tag", 32'(bus.rd_addr_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 34);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 34);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 34);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 34);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 34);
    run_op("mulh_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 5'd8, 32'hFFFF_FFFF, 34);
    run_op("div0", 3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    run_op("remu0", 3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
    run_op("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, 34);
    run_op("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF, 34);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd15, 32'd14, 34);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd16, 32'd2, 34);

    // Flush ten cycles into a DIV: nothing completes and the old result stays.
    bus.start_i = 1'b1;
    bus.op_i = 3'd4;
    bus.rs1_i = 32'd1000;
    bus.rs2_i = 32'd3;
    bus.rd_addr_i = 5'd17;
    tick();
    bus.start_i = 1'b0;
    repeat (10) tick();
    chk("pre_flush_busy", 32'(bus.busy_o), 32'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush_busy", 32'(bus.busy_o), 32'd0);
    chk("flush_done", 32'(bus.done_o), 32'd0);
    chk("flush_res", bus.result_o, 32'd2);
    chk("flush_tag", 32'(bus.rd_addr_o), 32'd16);
    run_op("post_flush", 3'd5, 32'd1000, 32'd3, 5'd18, 32'd333, 34);

    // A second start while busy is dropped; only one completion follows.
    bus.start_i = 1'b1;
    bus.op_i = 3'd0;
    bus.rs1_i = 32'd6;
    bus.rs2_i = 32'd7;
    bus.rd_addr_i = 5'd19;
    tick();
    bus.start_i = 1'b0;
    ndone = 0;
    got_res = '0;
    got_tag = '0;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) begin
        bus.start_i = 1'b1;
        bus.rs1_i = 32'd2;
        bus.rs2_i = 32'd3;
        bus.rd_addr_i = 5'd20;
      end else begin
        bus.start_i = 1'b0;
      end
      tick();
      if (bus.done_o) begin
        ndone++;
        got_res = bus.result_o;
        got_tag = bus.rd_addr_o;
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_res", got_res, 32'd42);
    chk("ign_tag", 32'(got_tag), 32'd19);

    // Start held in the done cycle: next result lands exactly 34 edges later.
    bus.start_i = 1'b1;
    bus.op_i = 3'd0;
    bus.rs1_i = 32'd3;
    bus.rs2_i = 32'd5;
    bus.rd_addr_i = 5'd1;
    tick();
    bus.start_i = 1'b0;
    cnt = 1;
    while (!bus.done_o && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("b2b_first_done", 32'(bus.done_o), 32'd1);
    chk("b2b_first_res", bus.result_o, 32'd15);
    bus.start_i = 1'b1;
    bus.op_i = 3'd5;
    bus.rs1_i = 32'd50;
    bus.rs2_i = 32'd5;
    bus.rd_addr_i = 5'd2;
    tick();
    bus.start_i = 1'b0;
    cnt = 1;
    while (!bus.done_o && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("b2b_gap", cnt, 34);
    chk("b2b_res", bus.result_o, 32'd10);
    chk("b2b_tag", 32'(bus.rd_addr_o), 32'd2);
    tick();

    // Reset in the middle of CALC clears every output.
    bus.start_i = 1'b1;
    bus.op_i = 3'd0;
    bus.rs1_i = 32'd9;
    bus.rs2_i = 32'd9;
    bus.rd_addr_i = 5'd21;
    tick();
    bus.start_i = 1'b0;
    repeat (5) tick();
    chk("mid_busy", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", 32'(bus.busy_o), 32'd0);
    chk("mrst_done", 32'(bus.done_o), 32'd0);
    chk("mrst_res", bus.result_o, 32'd0);
    chk("mrst_tag", 32'(bus.rd_addr_o), 32'd0);
    chk("mrst_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    repeat (40) tick();
    chk("mrst_nodone", 32'(bus.done_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
